multi_delay: RTL and testbench

- Multi-channel programmable one-shot delay timer; generational successor of the single-channel fixed-delay block.
- Each channel takes a trigger, waits a run-time delay value, then emits a one-cycle `out` pulse.
- Adds per-channel delay values, a retrigger mode, cancel, busy status and sticky overrun flags.
- Sequences decoder control events, e.g. traceback start after ACS fill, or output-valid after pipeline latency.

---
 rtl/multi_delay_pkg.sv | 12 +
 rtl/delay_chan.sv | 92 +++++++++
 rtl/multi_delay.sv | 60 ++++++
 tb/tb_multi_delay.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_delay_pkg.sv
// Shared types for the multi-channel programmable one-shot delay timer.
package multi_delay_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } chan_state_t;

    localparam int unsigned NCH_DEFAULT   = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/delay_chan.sv
// One delay channel: down-counter with terminal-count fire, retrigger/cancel
// handling, and registered out/busy/sticky-overrun outputs.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for a trigger; out may still be high from last fire
//  ST_COUNT | counting down the latched delay; fires when cnt reaches 0
module delay_chan
    import multi_delay_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay_val,
    input  logic             retrig,
    input  logic             cancel,
    input  logic             clr_ovr,
    output logic             out,
    output logic             busy,
    output logic             ovr
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        if (enable) begin
            out_d = 1'b0;

            if (cancel) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (trig && (state_q == ST_IDLE)) begin
                state_d = ST_COUNT;
                cnt_d   = delay_val;
            end else if (trig && retrig) begin
                // Reload while counting; a fire due on this edge is dropped.
                cnt_d = delay_val;
            end else if (state_q == ST_COUNT) begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            if (clr_ovr) begin
                ovr_d = 1'b0;
            end
            // Set after clear so a coincident drop wins over clr_ovr.
            if (!cancel && trig && !retrig && (state_q == ST_COUNT)) begin
                ovr_d = 1'b1;
            end

            busy_d = (state_d == ST_COUNT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

endmodule

// File: rtl/multi_delay.sv
// Multi-channel programmable one-shot delay timer: NCH independent channels
// plus a registered OR of all channel pulses.
module multi_delay
    import multi_delay_pkg::*;
#(
    parameter int unsigned NCH   = NCH_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NCH-1:0]       trig,
    input  logic [NCH*CNT_W-1:0] delay_val,
    input  logic                 retrig,
    input  logic [NCH-1:0]       cancel,
    input  logic                 clr_ovr,
    output logic [NCH-1:0]       out,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       ovr,
    output logic                 any_out
);

    logic any_out_q, any_out_d;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        delay_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .enable    (enable),
            .trig      (trig[i]),
            .delay_val (delay_val[i*CNT_W +: CNT_W]),
            .retrig    (retrig),
            .cancel    (cancel[i]),
            .clr_ovr   (clr_ovr),
            .out       (out[i]),
            .busy      (busy[i]),
            .ovr       (ovr[i])
        );
    end

    always_comb begin
        any_out_d = any_out_q;
        if (enable) begin
            any_out_d = |out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_out_q <= 1'b0;
        end else begin
            any_out_q <= any_out_d;
        end
    end

    assign any_out = any_out_q;

endmodule

// File: tb/tb_multi_delay.sv
// Directed self-checking bench for multi_delay (NCH=4, CNT_W=8).
`timescale 1ns/1ps
module tb_multi_delay;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [NCH-1:0]       trig;
    logic [NCH*CNT_W-1:0] delay_val;
    logic                 retrig;
    logic [NCH-1:0]       cancel;
    logic                 clr_ovr;
    logic [NCH-1:0]       out;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       ovr;
    logic                 any_out;

    int n_cmp = 0;
    int n_err = 0;

    multi_delay #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .trig      (trig),
        .delay_val (delay_val),
        .retrig    (retrig),
        .cancel    (cancel),
        .clr_ovr   (clr_ovr),
        .out       (out),
        .busy      (busy),
        .ovr       (ovr),
        .any_out   (any_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        trig      = '0;
        delay_val = '0;
        retrig    = 1'b0;
        cancel    = '0;
        clr_ovr   = 1'b0;
        idle(2);
        n_cmp++;
        if (out !== 4'b0) begin n_err++; $display("FAIL reset_out got=%b exp=0000", out); end
        n_cmp++;
        if (busy !== 4'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0000", busy); end
        n_cmp++;
        if (ovr !== 4'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0000", ovr); end
        n_cmp++;
        if (any_out !== 1'b0) begin n_err++; $display("FAIL reset_any got=%b exp=0", any_out); end
        rst_n = 1'b1;
        idle(2);
    endtask

    // ch0 D=5: out after edge k+6, busy after k..k+5, any_out after k+7.
    task automatic test_basic();
        delay_val[0 +: 8] = 8'd5;
        trig = 4'b0001;
        tick();
        trig = '0;
        n_cmp++;
        if (busy[0] !== 1'b1 || out[0] !== 1'b0) begin
            n_err++; $display("FAIL basic_accept busy=%b out=%b exp busy=1 out=0", busy[0], out[0]);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (out[0] !== (i == 6)) begin n_err++; $display("FAIL basic_out edge+%0d got=%b exp=%b", i, out[0], (i == 6)); end
            n_cmp++;
            if (busy[0] !== (i < 6)) begin n_err++; $display("FAIL basic_busy edge+%0d got=%b exp=%b", i, busy[0], (i < 6)); end
            n_cmp++;
            if (any_out !== (i == 7)) begin n_err++; $display("FAIL basic_any edge+%0d got=%b exp=%b", i, any_out, (i == 7)); end
        end
    endtask

    // ch1 D=0 and ch2 D=255 launched together.
    task automatic test_extremes();
        logic [3:0] exp;
        delay_val[8 +: 8]  = 8'd0;
        delay_val[16 +: 8] = 8'd255;
        trig = 4'b0110;
        tick();
        trig = '0;
        for (int i = 1; i <= 258; i++) begin
            tick();
            exp = 4'b0000;
            if (i == 1)   exp[1] = 1'b1;
            if (i == 256) exp[2] = 1'b1;
            n_cmp++;
            if (out !== exp) begin n_err++; $display("FAIL extremes_out edge+%0d got=%b exp=%b", i, out, exp); end
        end
    endtask

    // Trigger in IDLE while out is still high is accepted.
    task automatic test_back_to_back();
        delay_val[0 +: 8] = 8'd1;
        trig = 4'b0001;
        tick();
        trig = '0;
        for (int i = 1; i <= 7; i++) begin
            trig = (i == 3) ? 4'b0001 : 4'b0000;
            tick();
            n_cmp++;
            if (out[0] !== (i == 2 || i == 5)) begin
                n_err++; $display("FAIL b2b_out edge+%0d got=%b exp=%b", i, out[0], (i == 2 || i == 5));
            end
            n_cmp++;
            if (busy[0] !== (i < 2 || i == 3 || i == 4)) begin
                n_err++; $display("FAIL b2b_busy edge+%0d got=%b exp=%b", i, busy[0], (i < 2 || i == 3 || i == 4));
            end
        end
        trig = '0;
    endtask

    task automatic retrig_run(input logic mode, input int fire_at);
        logic exp_ovr;
        retrig = mode;
        delay_val[0 +: 8] = 8'd10;
        trig = 4'b0001;
        tick();
        trig = '0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 6) begin
                delay_val[0 +: 8] = 8'd3;
                trig = 4'b0001;
            end else begin
                trig = 4'b0000;
            end
            tick();
            exp_ovr = (mode == 1'b0) && (i >= 6);
            n_cmp++;
            if (out[0] !== (i == fire_at)) begin
                n_err++; $display("FAIL retrig%0d_out edge+%0d got=%b exp=%b", mode, i, out[0], (i == fire_at));
            end
            n_cmp++;
            if (ovr[0] !== exp_ovr) begin
                n_err++; $display("FAIL retrig%0d_ovr edge+%0d got=%b exp=%b", mode, i, ovr[0], exp_ovr);
            end
        end
    endtask

    task automatic test_retrig();
        retrig_run(1'b1, 10);
        retrig_run(1'b0, 11);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        n_cmp++;
        if (ovr !== 4'b0000) begin n_err++; $display("FAIL clr_ovr got=%b exp=0000", ovr); end
        // Set and clear on the same edge: set wins.
        delay_val[0 +: 8] = 8'd4;
        trig = 4'b0001;
        tick();
        clr_ovr = 1'b1;
        tick();
        trig = '0;
        clr_ovr = 1'b0;
        n_cmp++;
        if (ovr[0] !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins got=%b exp=1", ovr[0]); end
        clr_ovr = 1'b1;
        idle(6);
        clr_ovr = 1'b0;
        retrig = 1'b0;
    endtask

    task automatic test_cancel_reset();
        delay_val[24 +: 8] = 8'd20;
        trig = 4'b1000;
        tick();
        trig = '0;
        for (int i = 1; i <= 25; i++) begin
            trig   = (i == 5) ? 4'b1000 : 4'b0000;
            cancel = (i == 5) ? 4'b1000 : 4'b0000;
            tick();
            n_cmp++;
            if (busy[3] !== (i < 5)) begin n_err++; $display("FAIL cancel_busy edge+%0d got=%b exp=%b", i, busy[3], (i < 5)); end
            n_cmp++;
            if (out[3] !== 1'b0) begin n_err++; $display("FAIL cancel_out edge+%0d got=%b exp=0", i, out[3]); end
        end
        trig = '0;
        cancel = '0;
        trig = 4'b1000;
        tick();
        trig = '0;
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out, busy, ovr, any_out} !== 13'b0) begin
            n_err++; $display("FAIL midreset_outputs got=%b/%b/%b/%b exp=0", out, busy, ovr, any_out);
        end
        #6;
        rst_n = 1'b1;
        #1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if (out !== 4'b0000 || busy !== 4'b0000) begin
                n_err++; $display("FAIL midreset_after edge+%0d out=%b busy=%b exp=0000", i, out, busy);
            end
        end
    endtask

    // ch0 D=4, enable low 3 cycles mid-count, then low across the pulse.
    task automatic test_enable();
        logic exp_out;
        delay_val[0 +: 8] = 8'd4;
        trig = 4'b0001;
        tick();
        trig = '0;
        for (int i = 1; i <= 12; i++) begin
            enable = !(i inside {2, 3, 4, 9, 10});
            tick();
            exp_out = (i >= 8 && i <= 10);
            n_cmp++;
            if (out[0] !== exp_out) begin n_err++; $display("FAIL enable_out edge+%0d got=%b exp=%b", i, out[0], exp_out); end
            n_cmp++;
            if (busy[0] !== (i < 8)) begin n_err++; $display("FAIL enable_busy edge+%0d got=%b exp=%b", i, busy[0], (i < 8)); end
            n_cmp++;
            if (any_out !== (i == 11)) begin n_err++; $display("FAIL enable_any edge+%0d got=%b exp=%b", i, any_out, (i == 11)); end
        end
        enable = 1'b1;
        // Trigger dropped while disabled is lost.
        enable = 1'b0;
        trig = 4'b0001;
        tick();
        trig = '0;
        enable = 1'b1;
        tick();
        n_cmp++;
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL enable_lost_trig busy=%b exp=0", busy[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        idle(3);
        test_extremes();
        idle(3);
        test_back_to_back();
        idle(3);
        test_retrig();
        idle(3);
        test_cancel_reset();
        idle(3);
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
